// File: rtl/bpsk_frame_ctrl.sv
// BPSK frame sequencer: preamble, sync word, then byte payload, one bit per SYM_LEN clocks.
// Payload bytes arrive over a valid/ready port into a one-byte holding buffer.
module bpsk_frame_ctrl #(
  parameter int unsigned SYM_LEN   = 120,
  parameter int unsigned PRE_BITS  = 32,
  parameter logic [15:0] SYNC_WORD = 16'hA5F0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       bpsk_base_data,
  output logic       tx_active,
  output logic       frame_done,
  output logic       underrun
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BIT_W  = 8;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SH_W   = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    SYNC     = 2'd2,
    PAYLOAD  = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  sym_cnt, sym_cnt_d;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
  logic [BYTE_W-1:0] len_q, len_d;
  logic [BYTE_W-1:0] acc_cnt, acc_d;
  logic [BYTE_W-1:0] sent_cnt, sent_d;
  logic [7:0]        buf_q, buf_d;
  logic              buf_full, buf_full_d;
  logic [SH_W-1:0]   shreg, shreg_d;
  logic              bit_d, active_d, done_d, urun_d;
  logic              boundary, handshake, load_req;

  assign boundary   = (sym_cnt == CNT_W'(SYM_LEN - 1));
  assign data_ready = ((state == SYNC) || (state == PAYLOAD)) && !buf_full && (acc_cnt < len_q);
  assign handshake  = data_ready & data_valid;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      sym_cnt        <= '0;
      bit_cnt        <= '0;
      len_q          <= '0;
      acc_cnt        <= '0;
      sent_cnt       <= '0;
      buf_q          <= '0;
      buf_full       <= 1'b0;
      shreg          <= '0;
      bpsk_base_data <= 1'b0;
      tx_active      <= 1'b0;
      frame_done     <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      state          <= state_d;
      sym_cnt        <= sym_cnt_d;
      bit_cnt        <= bit_cnt_d;
      len_q          <= len_d;
      acc_cnt        <= acc_d;
      sent_cnt       <= sent_d;
      buf_q          <= buf_d;
      buf_full       <= buf_full_d;
      shreg          <= shreg_d;
      bpsk_base_data <= bit_d;
      tx_active      <= active_d;
      frame_done     <= done_d;
      underrun       <= urun_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state;
    sym_cnt_d  = sym_cnt;
    bit_cnt_d  = bit_cnt;
    len_d      = len_q;
    acc_d      = acc_cnt;
    sent_d     = sent_cnt;
    buf_d      = buf_q;
    buf_full_d = buf_full;
    shreg_d    = shreg;
    bit_d      = bpsk_base_data;
    active_d   = tx_active;
    done_d     = 1'b0;
    urun_d     = underrun;
    load_req   = 1'b0;

    if (state != IDLE) begin
      sym_cnt_d = boundary ? '0 : sym_cnt + CNT_W'(1);
    end

    if (handshake) begin
      buf_d      = data_in;
      buf_full_d = 1'b1;
      acc_d      = acc_cnt + BYTE_W'(1);
    end

    case (state)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          state_d    = PREAMBLE;
          len_d      = frame_len;
          acc_d      = '0;
          sent_d     = '0;
          buf_full_d = 1'b0;
          sym_cnt_d  = '0;
          bit_cnt_d  = '0;
          bit_d      = 1'b1;
          active_d   = 1'b1;
          urun_d     = 1'b0;
        end
      end

      PREAMBLE: begin
        if (boundary) begin
          if (bit_cnt == BIT_W'(PRE_BITS - 1)) begin
            state_d   = SYNC;
            bit_cnt_d = '0;
            shreg_d   = SYNC_WORD;
            bit_d     = SYNC_WORD[15];
          end else begin
            // Next bit index is even (a 1) exactly when the current index is odd
            bit_cnt_d = bit_cnt + BIT_W'(1);
            bit_d     = bit_cnt[0];
          end
        end
      end

      SYNC: begin
        if (boundary) begin
          if (bit_cnt == BIT_W'(15)) begin
            load_req = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt + BIT_W'(1);
            shreg_d   = {shreg[SH_W-2:0], 1'b0};
            bit_d     = shreg[SH_W-2];
          end
        end
      end

      PAYLOAD: begin
        if (boundary) begin
          if (bit_cnt == BIT_W'(7)) begin
            if (sent_cnt == len_q) begin
              state_d  = IDLE;
              bit_d    = 1'b0;
              active_d = 1'b0;
              done_d   = 1'b1;
            end else begin
              load_req = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt + BIT_W'(1);
            shreg_d   = {shreg[SH_W-2:0], 1'b0};
            bit_d     = shreg[SH_W-2];
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Byte boundary: only a byte already held before this edge can be sent
    if (load_req) begin
      if (buf_full) begin
        state_d    = PAYLOAD;
        bit_cnt_d  = '0;
        shreg_d    = {buf_q, 8'h00};
        bit_d      = buf_q[7];
        buf_full_d = 1'b0;
        sent_d     = sent_cnt + BYTE_W'(1);
      end else begin
        state_d   = IDLE;
        sym_cnt_d = '0;
        bit_d     = 1'b0;
        active_d  = 1'b0;
        urun_d    = 1'b1;
      end
    end
  end

endmodule

// File: doc/bpsk_frame_ctrl.md
# bpsk_frame_ctrl

Symbol-rate frame sequencer that drives the `bpsk_base_data` input of the BPSK modulator. On a start request it emits a fixed preamble, then a 16-bit sync word, then a payload of `frame_len` bytes pulled through a valid/ready byte interface. Every bit is held for exactly `SYM_LEN` clock cycles. It sits between the packet source and the modulator and runs on the modulator's sampling clock.

## Interface
- `SYM_LEN`, 120: clock cycles per symbol (120 gives 1 Mbaud at 120 MHz); legal range 2..65535.
- `PRE_BITS`, 32: preamble length in bits, alternating pattern starting with 1 (1,0,1,0,...); legal range 2..255.
- `SYNC_WORD`, 16'hA5F0: sync word, sent MSB first.
- `clk`  in  1  sampling clock, shared with the modulator.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `frame_len`  in  8  payload byte count; latched on an accepted `start`.
- `data_in`  in  8  payload byte.
- `data_valid`  in  1  `data_in` is valid.
- `data_ready`  out  1  controller accepts a byte this cycle when `data_valid` is also high.
- `bpsk_base_data`  out  1  registered bit to the modulator (1 = 180° phase).
- `tx_active`  out  1  high for every symbol cycle of a frame.
- `frame_done`  out  1  one-cycle pulse when a frame completes normally.
- `underrun`  out  1  sticky error flag; cleared by the next accepted `start`.

## Operation
- States: IDLE, PREAMBLE, SYNC, PAYLOAD.
- Symbol counter `sym_cnt` counts 0..SYM_LEN-1. A symbol boundary is the cycle where `sym_cnt == SYM_LEN-1`. The bit shifts only at boundaries.
- **IDLE to PREAMBLE:** on `start=1` with `frame_len != 0`. Latch `frame_len`, clear `underrun`, set `sym_cnt=0`, bit counter 0.
- `start` with `frame_len == 0` is ignored.
- `start` outside IDLE is ignored.
- **PREAMBLE to SYNC:** at the boundary of preamble bit PRE_BITS-1.
- **SYNC to PAYLOAD:** at the boundary of sync bit 15. At that boundary, the holding buffer byte moves into the shift register.
- Payload bytes are sent MSB first.
- Holding buffer is 1 byte.
  - `data_ready = 1` when state is SYNC or PAYLOAD, the buffer is empty, and bytes accepted < latched length.
  - A handshake (`data_valid & data_ready`) fills the buffer.
  - At each byte-end boundary (bit 7 of the current byte) with bytes remaining, the buffer moves to the shift register and the buffer is emptied.
- **Underrun:** the buffer is empty at a boundary where a byte must be loaded (end of SYNC, or a payload byte end with bytes remaining). Then:
  - set `underrun=1`;
  - go to IDLE;
  - `tx_active` and `bpsk_base_data` fall to 0 the next cycle;
  - no `frame_done`.
- **PAYLOAD to IDLE:** at the boundary of the last bit of the last byte. `frame_done` pulses.
- In IDLE: `bpsk_base_data=0`, `tx_active=0`, `data_ready=0`.
- Reset values: all outputs 0, state IDLE, counters 0, buffer empty.
- Reset asserted mid-frame aborts immediately, with no `frame_done` and no `underrun`.

## Timing
- Accepted `start` at edge N: `tx_active=1` and `bpsk_base_data=1` (first preamble bit) are visible from cycle N+1.
- Each bit is stable for exactly SYM_LEN consecutive cycles; no glitches between bits.
- Frame length in cycles: `(PRE_BITS + 16 + 8*frame_len) * SYM_LEN`, with `tx_active` high for exactly this many cycles.
- `frame_done` is high in the first cycle after the last symbol cycle, the same cycle `tx_active` returns to 0.
- A new `start` is accepted in that same cycle; back-to-back frames have a 1-cycle gap.
- `data_ready` is combinational from state and buffer status; it does not depend on `data_valid`.
- A byte accepted in the same cycle as a load boundary is not enough to avoid underrun. It must be accepted at least one cycle before the boundary.
- Counter widths: `sym_cnt` 16 bits, bit counter 8 bits, byte counter 8 bits. No wrap occurs within legal parameters.

## Test plan
- **Basic frame:** SYM_LEN=4, PRE_BITS=4, `frame_len=1`, byte 0x81 held valid → `bpsk_base_data` sequence 1010, A5F0 MSB first, then 10000001, each bit 4 cycles; `tx_active` high for 112 cycles; `frame_done` pulses at cycle 113; `underrun=0`.
- **Multi-byte with throttled source:** `frame_len=3` (0x00, 0xFF, 0x3C), `data_valid` asserted 2 cycles after each `data_ready` rise → exact payload bits, no underrun, one byte accepted per `data_ready` window.
- **Underrun:** `frame_len=2`, only the first byte supplied → `underrun=1` at the end of byte 0; `tx_active=0` the next cycle; no `frame_done`; the next `start` clears `underrun`.
- **Ignored starts:** `start` with `frame_len=0` → stays IDLE. `start` pulsed mid-PAYLOAD → frame unaffected and total length unchanged.
- **Back-to-back:** `start` held high continuously, `frame_len=1` → second frame's `tx_active` rises exactly 1 cycle after the first falls, coincident with `frame_done`.
- **Reset mid-frame:** `rst` low during SYNC → all outputs 0 asynchronously. After release, IDLE, and a new frame runs correctly.
